// File: rtl/neuron_seq_ctrl.sv
// Sequencer for one MAC+ReLU neuron: clears the accumulator, streams
// activation/weight pairs into it, waits for it to settle, then holds the result.
module neuron_seq_ctrl #(
   parameter int WIDTH   = 8,
   parameter int MAX_LEN = 16,
   parameter int CNT_W   = 5
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic [CNT_W-1:0]        len,
   output logic                    busy,
   input  logic signed [WIDTH-1:0] x_in,
   input  logic                    x_valid,
   output logic                    x_ready,
   output logic [CNT_W-1:0]        w_addr,
   input  logic signed [WIDTH-1:0] w_data,
   output logic                    neuron_rst,
   output logic                    neuron_en,
   output logic signed [WIDTH-1:0] neuron_W,
   output logic signed [WIDTH-1:0] neuron_X,
   input  logic signed [WIDTH-1:0] neuron_out,
   output logic [WIDTH-1:0]        res_data,
   output logic                    res_valid,
   input  logic                    res_ready
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      CLEAR  = 3'd1,
      ACCUM  = 3'd2,
      FLUSH  = 3'd3,
      SETTLE = 3'd4,
      DONE   = 3'd5
   } state_t;

   localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_LEN);
   localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

   state_t                    state_q, state_d;
   logic [CNT_W-1:0]          cnt_q, cnt_d;
   logic [CNT_W-1:0]          len_q, len_d;
   logic signed [WIDTH-1:0]   x_q, x_d;
   logic                      en_q, en_d;
   logic                      nrst_q, nrst_d;
   logic                      busy_q, busy_d;
   logic                      rv_q, rv_d;
   logic [WIDTH-1:0]          res_q, res_d;
   logic                      hs;
   logic                      last_hs;

   // State and datapath registers; every output that has a reset value is a flop.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         len_q   <= '0;
         x_q     <= '0;
         en_q    <= 1'b0;
         nrst_q  <= 1'b0;
         busy_q  <= 1'b0;
         rv_q    <= 1'b0;
         res_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         len_q   <= len_d;
         x_q     <= x_d;
         en_q    <= en_d;
         nrst_q  <= nrst_d;
         busy_q  <= busy_d;
         rv_q    <= rv_d;
         res_q   <= res_d;
      end
   end

   assign x_ready = (state_q == ACCUM) && (cnt_q < len_q);
   assign hs      = x_ready && x_valid;
   assign last_hs = hs && ((cnt_q + ONE_C) == len_q);

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (start) state_d = CLEAR;
         CLEAR:   state_d = (len_q != '0) ? ACCUM : SETTLE;
         ACCUM:   if (last_hs) state_d = FLUSH;
         FLUSH:   state_d = SETTLE;
         SETTLE:  state_d = DONE;
         DONE:    if (res_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Registered outputs are derived from the next state so they line up with it.
   always_comb begin
      cnt_d  = cnt_q;
      len_d  = len_q;
      x_d    = x_q;
      en_d   = hs;
      res_d  = res_q;
      if (state_q == IDLE && start) begin
         cnt_d = '0;
         len_d = (len > MAX_C) ? MAX_C : len;
      end
      if (hs) begin
         cnt_d = cnt_q + ONE_C;
         x_d   = x_in;
      end
      if (state_q == SETTLE) res_d = neuron_out;
      nrst_d = (state_d != CLEAR);
      busy_d = (state_d != IDLE);
      rv_d   = (state_d == DONE);
   end

   // The pair handshaken in cycle N meets its weight (1-cycle memory) in cycle N+1.
   assign w_addr     = cnt_q;
   assign neuron_en  = en_q;
   assign neuron_X   = x_q;
   assign neuron_W   = w_data;
   assign neuron_rst = nrst_q;
   assign busy       = busy_q;
   assign res_valid  = rv_q;
   assign res_data   = res_q;

endmodule
